// File: rtl/xm23_pkg.sv
// Shared types and constants for the XM23 data-RAM port arbiter.
package xm23_pkg;

    typedef enum logic [1:0] {
        ARB_CPU   = 2'd0,
        ARB_BOOST = 2'd1,
        ARB_LOCK  = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rd_owner_pipe.sv
// Read-owner tracking: carries a valid/owner tag alongside each read through
// the RAM latency, then captures mem_q into the owning port's read-data register.
module rd_owner_pipe
    import xm23_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_valid,
    input  logic        push_owner,
    input  logic [15:0] mem_q,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    output logic        dbg_rvalid,
    output logic [15:0] dbg_rdata
);

    logic [READ_LATENCY-1:0] valid_q, valid_d;
    logic [READ_LATENCY-1:0] owner_q, owner_d;
    logic                    cpu_rvalid_q, cpu_rvalid_d;
    logic                    dbg_rvalid_q, dbg_rvalid_d;
    logic [15:0]             cpu_rdata_q, cpu_rdata_d;
    logic [15:0]             dbg_rdata_q, dbg_rdata_d;
    logic                    tail_valid;
    logic                    tail_owner;

    // Advance the owner/valid tags one stage per cycle.
    always_comb begin
        valid_d    = '0;
        owner_d    = '0;
        valid_d[0] = push_valid;
        owner_d[0] = push_owner;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            owner_d[i] = owner_q[i-1];
        end
    end

    // At the tail, steer mem_q to the owner; the other port keeps its data.
    always_comb begin
        tail_valid   = valid_q[READ_LATENCY-1];
        tail_owner   = owner_q[READ_LATENCY-1];
        cpu_rvalid_d = tail_valid & (tail_owner == OWNER_CPU);
        dbg_rvalid_d = tail_valid & (tail_owner == OWNER_DBG);
        cpu_rdata_d  = cpu_rvalid_d ? mem_q : cpu_rdata_q;
        dbg_rdata_d  = dbg_rvalid_d ? mem_q : dbg_rdata_q;
    end

    // Tag pipeline and read-data registers; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= '0;
            owner_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            owner_q      <= owner_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single d_ram port between the CPU memory stage and the debug
// port. CPU has priority; a starvation counter boosts the debug port for one
// grant, and dbg_lock gives the debug port exclusive ownership.
module dram_port_arbiter
    import xm23_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DBG_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    input  logic        dbg_lock,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [15:0] dbg_rdata,
    output logic        locked,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wren,
    input  logic [15:0] mem_q
);

    localparam int unsigned WAIT_W =
        ($clog2(DBG_MAX_WAIT + 1) > 4) ? $clog2(DBG_MAX_WAIT + 1) : 4;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(DBG_MAX_WAIT - 1);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [14:0]       mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    mem_req_t          cpu_rq, dbg_rq, sel_rq;
    logic              dbg_refused;
    logic              unused_addr_lsb;

    // Per-cycle grant decision from the registered state; nothing granted in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst_n) begin
            case (state_q)
                ARB_CPU: begin
                    cpu_gnt = cpu_req;
                    dbg_gnt = dbg_req & ~cpu_req;
                end
                ARB_BOOST: begin
                    dbg_gnt = dbg_req;
                    cpu_gnt = cpu_req & ~dbg_req;
                end
                ARB_LOCK: begin
                    dbg_gnt = dbg_req;
                end
                default: ;
            endcase
        end
    end

    // Drive the RAM from the winner; address/data hold when nobody is granted.
    always_comb begin
        cpu_rq      = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        dbg_rq      = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
        sel_rq      = dbg_gnt ? dbg_rq : cpu_rq;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren    = 1'b0;
        if (cpu_gnt | dbg_gnt) begin
            mem_addr_d  = sel_rq.addr[15:1];
            mem_wdata_d = sel_rq.wdata;
            mem_wren    = sel_rq.we;
        end
    end

    assign unused_addr_lsb = sel_rq.addr[0];
    assign mem_addr        = mem_addr_d;
    assign mem_wdata       = mem_wdata_d;
    assign cpu_stall       = rst_n & cpu_req & ~cpu_gnt;
    assign locked          = (state_q == ARB_LOCK);
    assign dbg_refused     = dbg_req & ~dbg_gnt;

    // Starvation counter and next-state selection; lock overrides boost.
    always_comb begin
        wait_cnt_d = '0;
        if (dbg_refused) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        state_d = state_q;
        if (dbg_lock) begin
            state_d = ARB_LOCK;
        end else begin
            case (state_q)
                ARB_CPU: begin
                    if (dbg_refused && (wait_cnt_q == WAIT_LIMIT)) begin
                        state_d = ARB_BOOST;
                    end
                end
                ARB_BOOST: begin
                    if (dbg_gnt || !dbg_req) begin
                        state_d = ARB_CPU;
                    end
                end
                ARB_LOCK: state_d = ARB_CPU;
                default:  state_d = ARB_CPU;
            endcase
        end
    end

    // Arbiter state, starvation counter and held RAM address/data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_CPU;
            wait_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    rd_owner_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_owner_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid ((cpu_gnt | dbg_gnt) & ~sel_rq.we),
        .push_owner (dbg_gnt ? OWNER_DBG : OWNER_CPU),
        .mem_q      (mem_q),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata)
    );

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed stimulus with literal checks, plus a
// per-cycle compare against a behavioural model of the arbitration rules.
module tb_dram_port_arbiter;

    localparam int RL = 1;
    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, locked, mem_wren;
    logic [15:0] cpu_rdata, dbg_rdata, mem_wdata, mem_q;
    logic [14:0] mem_addr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dram_port_arbiter #(.READ_LATENCY(RL), .DBG_MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .locked(locked), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    // RAM stand-in with RL cycles of read latency.
    logic [15:0] ram [0:32767];
    logic [15:0] rd_pipe [0:RL-1];
    initial for (int i = 0; i < 32768; i++) ram[i] = 16'h0000;
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        rd_pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_q = rd_pipe[RL-1];

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        bit          to_dbg;
        logic [15:0] data;
    } ret_t;

    ret_t        pend[$];
    logic [15:0] m_mem [int];
    bit          m_ok = 0;
    bit          m_locked = 0;
    bit          m_boost = 0;
    int          m_refused = 0;
    int          cyc = 0;
    logic [15:0] m_cr = '0, m_dr = '0, m_lw = '0;
    logic [14:0] m_la = '0;

    always @(negedge clk) begin
        bit          e_cg, e_dg, e_crv, e_drv, e_we;
        logic [14:0] e_addr;
        logic [15:0] e_wd;
        ret_t        r;

        // Who must win this cycle.
        e_cg = 0;
        e_dg = 0;
        if (rst_n === 1'b1) begin
            if (m_locked) e_dg = dbg_req;
            else if (m_boost) begin
                e_dg = dbg_req;
                e_cg = cpu_req && !dbg_req;
            end else begin
                e_cg = cpu_req;
                e_dg = dbg_req && !cpu_req;
            end
        end
        e_addr = e_cg ? cpu_addr[15:1] : e_dg ? dbg_addr[15:1] : m_la;
        e_wd   = e_cg ? cpu_wdata : e_dg ? dbg_wdata : m_lw;
        e_we   = (e_cg && cpu_we) || (e_dg && dbg_we);

        e_crv = 0;
        e_drv = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            if (r.to_dbg) begin e_drv = 1; m_dr = r.data; end
            else          begin e_crv = 1; m_cr = r.data; end
        end

        chk1("cmp_cpu_gnt", cpu_gnt, e_cg);
        chk1("cmp_dbg_gnt", dbg_gnt, e_dg);
        chk1("cmp_cpu_stall", cpu_stall, (rst_n === 1'b1) && cpu_req && !e_cg);
        chk1("cmp_mem_wren", mem_wren, e_we);
        if (m_ok) begin
            chk16("cmp_mem_addr", {1'b0, mem_addr}, {1'b0, e_addr});
            chk16("cmp_mem_wdata", mem_wdata, e_wd);
            chk1("cmp_locked", locked, m_locked);
            chk1("cmp_cpu_rvalid", cpu_rvalid, e_crv);
            chk1("cmp_dbg_rvalid", dbg_rvalid, e_drv);
            chk16("cmp_cpu_rdata", cpu_rdata, m_cr);
            chk16("cmp_dbg_rdata", dbg_rdata, m_dr);
        end

        // What the next cycle looks like.
        cyc++;
        if (rst_n !== 1'b1) begin
            m_ok = 1; m_locked = 0; m_boost = 0; m_refused = 0;
            pend.delete();
            m_cr = '0; m_dr = '0; m_la = '0; m_lw = '0;
        end else begin
            if (e_cg || e_dg) begin
                m_la = e_addr;
                m_lw = e_wd;
                if (e_we) m_mem[int'(e_addr)] = e_wd;
                else begin
                    r.due    = cyc - 1 + RL + 1;
                    r.to_dbg = e_dg;
                    r.data   = m_mem.exists(int'(e_addr)) ? m_mem[int'(e_addr)] : 16'h0000;
                    pend.push_back(r);
                end
            end
            if (dbg_req && !e_dg) m_refused++;
            else m_refused = 0;
            if (dbg_lock) begin m_locked = 1; m_boost = 0; end
            else if (m_locked) begin m_locked = 0; m_boost = 0; end
            else if (m_boost) m_boost = dbg_req && !e_dg;
            else m_boost = (m_refused == MW);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic rn,
                         input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                         input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                         input logic dl);
        @(posedge clk);
        #1;
        rst_n = rn;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        dbg_lock = dl;
        #2;
    endtask

    task automatic idle();
        drive(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;

        // Reset with a CPU request pending.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0, 0);
            chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
            chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
            chk1("rst_cpu_stall", cpu_stall, 1'b0);
            chk1("rst_mem_wren", mem_wren, 1'b0);
        end
        chk1("rst_locked", locked, 1'b0);
        chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk16("rst_mem_addr", {1'b0, mem_addr}, 16'h0000);
        idle();

        // CPU write then read of byte address 0x0040.
        drive(1, 1, 1, 16'h0040, 16'h1234, 0, 0, 16'h0, 16'h0, 0);
        chk1("wr_gnt", cpu_gnt, 1'b1);
        chk1("wr_wren", mem_wren, 1'b1);
        chk16("wr_addr", {1'b0, mem_addr}, 16'h0020);
        chk16("wr_wdata", mem_wdata, 16'h1234);
        drive(1, 1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        chk1("rd_gnt", cpu_gnt, 1'b1);
        chk1("rd_wren", mem_wren, 1'b0);
        chk16("rd_addr", {1'b0, mem_addr}, 16'h0020);
        idle();
        chk1("rd_rvalid_n1", cpu_rvalid, 1'b0);
        chk16("rd_addr_hold", {1'b0, mem_addr}, 16'h0020);
        idle();
        chk1("rd_rvalid_n2", cpu_rvalid, 1'b1);
        chk16("rd_rdata", cpu_rdata, 16'h1234);
        idle();
        chk1("rd_rvalid_pulse", cpu_rvalid, 1'b0);
        chk16("rd_rdata_hold", cpu_rdata, 16'h1234);

        // Alternating-owner reads in consecutive cycles.
        drive(1, 1, 1, 16'h0010, 16'hAAAA, 0, 0, 16'h0, 16'h0, 0);
        drive(1, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0012, 16'h5555, 0);
        chk1("alt_dbg_wr_gnt", dbg_gnt, 1'b1);
        drive(1, 1, 1, 16'h0014, 16'h0F0F, 0, 0, 16'h0, 16'h0, 0);
        drive(1, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        chk1("alt_r0_gnt", cpu_gnt, 1'b1);
        drive(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0012, 16'h0, 0);
        chk1("alt_r1_gnt", dbg_gnt, 1'b1);
        chk16("alt_r1_addr", {1'b0, mem_addr}, 16'h0009);
        drive(1, 1, 0, 16'h0014, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        chk1("alt_c0_rvalid", cpu_rvalid, 1'b1);
        chk16("alt_c0_rdata", cpu_rdata, 16'hAAAA);
        chk1("alt_c0_dbg_quiet", dbg_rvalid, 1'b0);
        idle();
        chk1("alt_d0_rvalid", dbg_rvalid, 1'b1);
        chk16("alt_d0_rdata", dbg_rdata, 16'h5555);
        chk1("alt_d0_cpu_quiet", cpu_rvalid, 1'b0);
        chk16("alt_d0_cpu_hold", cpu_rdata, 16'hAAAA);
        idle();
        chk1("alt_c1_rvalid", cpu_rvalid, 1'b1);
        chk16("alt_c1_rdata", cpu_rdata, 16'h0F0F);
        chk1("alt_c1_dbg_quiet", dbg_rvalid, 1'b0);
        chk16("alt_c1_dbg_hold", dbg_rdata, 16'h5555);
        idle();

        // Both ports requesting every cycle: debug boosted every 9th cycle.
        for (int i = 1; i <= 20; i++) begin
            drive(1, 1, 0, 16'h0100, 16'h0, 1, 0, 16'h0200, 16'h0, 0);
            chk1("starve_dbg_gnt", dbg_gnt, (i == 9 || i == 18));
            chk1("starve_cpu_stall", cpu_stall, (i == 9 || i == 18));
        end
        for (int i = 0; i < 3; i++) idle();

        // Exclusive lock for 5 cycles with the CPU requesting throughout.
        for (int i = 1; i <= 7; i++) begin
            drive(1, 1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0, (i <= 5));
            chk1("lock_locked", locked, (i >= 2 && i <= 6));
            chk1("lock_cpu_gnt", cpu_gnt, !(i >= 2 && i <= 6));
            chk1("lock_cpu_stall", cpu_stall, (i >= 2 && i <= 6));
        end
        for (int i = 0; i < 3; i++) idle();

        // Reset landing on an in-flight debug read.
        drive(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0012, 16'h0, 0);
        chk1("mr_dbg_gnt", dbg_gnt, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive((i >= 2), 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
            chk1("mr_no_rvalid", dbg_rvalid, 1'b0);
        end
        chk16("mr_dbg_rdata", dbg_rdata, 16'h0000);
        drive(1, 1, 0, 16'h0040, 16'h0, 1, 0, 16'h0012, 16'h0, 0);
        chk1("mr_locked", locked, 1'b0);
        chk1("mr_cpu_first", cpu_gnt, 1'b1);
        chk1("mr_dbg_wait", dbg_gnt, 1'b0);
        for (int i = 0; i < 4; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Single-port arbiter that shares the XM23 data RAM (`d_ram`, one read/write port) between two requesters: the pipeline memory-access stage (CPU) and a host/debug port that loads and inspects data memory. It sits between `memory_access_d_ram` and `d_ram`, and it routes registered read data back to whichever requester issued the read. CPU traffic has priority. A starvation counter and an exclusive-lock mode guarantee the debug port forward progress. When the debug port wins, the block raises a stall toward the pipeline controller.

## Interface
Parameters:
- `READ_LATENCY`, default 1: cycles from address presentation to valid `mem_q`. Legal range 1–3.
- `DBG_MAX_WAIT`, default 8: consecutive cycles a pending debug request may be refused before it is boosted.

Ports:
- `clk` in 1: block clock, the same clock that drives `d_ram`.
- `rst_n` in 1: reset, synchronous and active-low. One clock; reset is synchronous and active-low.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: CPU write, 1 = write, 0 = read.
- `cpu_addr` in 16: CPU byte address. Bit 0 is ignored.
- `cpu_wdata` in 16: CPU write data.
- `cpu_gnt` out 1: CPU access accepted this cycle.
- `cpu_stall` out 1: CPU request pending but refused; feeds the pipeline controller stall logic.
- `cpu_rvalid` out 1: CPU read data valid, one-cycle pulse.
- `cpu_rdata` out 16: CPU read data.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata` in 1/1/16/16: debug request fields, same meaning as the CPU fields.
- `dbg_lock` in 1: request exclusive ownership of the RAM for the debug port.
- `dbg_gnt` out 1: debug access accepted this cycle.
- `dbg_rvalid` out 1: debug read data valid, one-cycle pulse.
- `dbg_rdata` out 16: debug read data.
- `locked` out 1: exclusive debug ownership is active.
- `mem_addr` out 15: word address to `d_ram`. Equals the granted requester's `addr[15:1]`.
- `mem_wdata` out 16: write data to `d_ram`.
- `mem_wren` out 1: write enable to `d_ram`.
- `mem_q` in 16: read data from `d_ram`.

## Operation
States:
- `ARB_CPU`: default state; the CPU has priority.
- `ARB_BOOST`: the debug port has priority for exactly one grant.
- `ARB_LOCK`: exclusive debug ownership.

Grant decision (combinational, per cycle):
- `ARB_CPU`: `cpu_req` → grant CPU. Otherwise `dbg_req` → grant debug.
- `ARB_BOOST`: `dbg_req` → grant debug. Otherwise `cpu_req` → grant CPU.
- `ARB_LOCK`: only debug may be granted; `cpu_req` is always refused.
- At most one grant per cycle.

Datapath and control outputs:
- `mem_addr`, `mem_wdata` and `mem_wren` are driven from the granted requester. `mem_wren = gnt & we`.
- With no grant: `mem_wren = 0`, and `mem_addr`/`mem_wdata` hold their last values.
- `cpu_stall = cpu_req & ~cpu_gnt`.

Starvation counter `wait_cnt`, 4 bits minimum, saturating:
- Increments each cycle that `dbg_req & ~dbg_gnt`.
- Clears on `dbg_gnt` or when `dbg_req` is low.

State transitions:
- `ARB_CPU` → `ARB_BOOST` when `wait_cnt == DBG_MAX_WAIT-1` and the debug port is refused this cycle.
- `ARB_BOOST` → `ARB_CPU` after a debug grant, or if `dbg_req` drops.
- Any state → `ARB_LOCK` when `dbg_lock` is sampled high. The state changes at the next edge, so `cpu_gnt` is suppressed from the following cycle.
- `ARB_LOCK` → `ARB_CPU` when `dbg_lock` is sampled low. `locked = (state == ARB_LOCK)`.
- Simultaneous `dbg_lock` high and boost condition: lock wins.

Read return:
- Each read grant pushes a 1-bit owner tag (0 = CPU, 1 = debug) plus a valid bit into a `READ_LATENCY`-deep shift register.
- At the tail, `mem_q` is captured into `cpu_rdata` or `dbg_rdata` and the matching `rvalid` pulses.
- The `rdata` of the non-addressed port holds its value.
- Writes produce no `rvalid`.
- Back-to-back reads from alternating owners must return in issue order with no loss.

## Timing
- Grant is same-cycle combinational from `req` and registered state; there is no request-to-grant latency when the requester wins.
- Read data: `rvalid` is asserted exactly `READ_LATENCY + 1` cycles after the grant edge. Default: grant in cycle N, `mem_q` valid in N+1, registered into `rdata`, `rvalid` high in N+2.
- Write: the RAM is written at the edge ending the grant cycle.
- Throughput: one access per cycle.
- Reset values, with `rst_n` low at an edge:
  - state `ARB_CPU`, `wait_cnt` 0, owner pipeline cleared.
  - `cpu_gnt`, `dbg_gnt`, `cpu_rvalid`, `dbg_rvalid`, `locked`, `mem_wren` = 0.
  - `cpu_rdata`, `dbg_rdata`, `mem_addr`, `mem_wdata` = 0.
  - `cpu_stall` = 0 while in reset.
- Reset mid-read: in-flight reads are discarded and no `rvalid` fires afterwards.
- Requesters hold `req` and its fields stable until they see `gnt`.

## Structure
- Shared package `xm23_pkg` holds:
  - the `arb_state_t` enum (`ARB_CPU`, `ARB_BOOST`, `ARB_LOCK`);
  - the `OWNER_CPU`/`OWNER_DBG` constants;
  - the `mem_req_t` struct (`we`, `addr`, `wdata`).
- Sub-module `rd_owner_pipe`: the parameterised owner/valid shift register plus the read-data capture and steering.

## Test plan
- Reset: hold `rst_n` = 0 with `cpu_req` = 1 → all grants, `rvalid` and `mem_wren` stay 0; `cpu_stall` = 0.
- CPU write 0x1234 to 0x0040, then CPU read of 0x0040 → `mem_addr` = 0x0020; `cpu_rvalid` 2 cycles after the read grant; `cpu_rdata` = 0x1234.
- CPU and debug request every cycle for 20 cycles with `DBG_MAX_WAIT` = 8 → debug granted in cycle 9 and every 9th cycle after; `cpu_stall` high only in those cycles.
- Alternating reads CPU@0x10 (0xAAAA), debug@0x12 (0x5555), CPU@0x14 (0x0F0F) in consecutive cycles → `rvalid`s appear in issue order with the correct data; no cross-delivery.
- `dbg_lock` = 1 for 5 cycles while `cpu_req` = 1 → `locked` = 1 from the next cycle; `cpu_gnt` = 0 and `cpu_stall` = 1 throughout; CPU granted on the cycle after `locked` falls.
- Debug read granted, then `rst_n` = 0 in the next cycle → no `dbg_rvalid` ever appears; state returns to `ARB_CPU`.
